// File: rtl/rv_plic_src_filter_if.sv
// Signal bundle between raw peripheral interrupt wires and the PLIC source filter.
// The master side drives raw lines and filter configuration; the slave side is the filter.
interface rv_plic_src_filter_if #(
  parameter int NumSrc = 64,
  parameter int CntW   = 4
);
  logic [NumSrc-1:0] raw_i;
  logic [NumSrc-1:0] filt_en_i;
  logic [CntW-1:0]   deb_cycles_i;
  logic [NumSrc-1:0] intr_src_o;
  logic [NumSrc-1:0] glitch_o;

  modport master (
    output raw_i,
    output filt_en_i,
    output deb_cycles_i,
    input  intr_src_o,
    input  glitch_o
  );

  modport slave (
    input  raw_i,
    input  filt_en_i,
    input  deb_cycles_i,
    output intr_src_o,
    output glitch_o
  );
endinterface

// File: rtl/rv_plic_src_filter.sv
// Per-source conditioning of raw interrupt lines ahead of rv_plic: synchroniser,
// optional debounce filter with glitch reporting, and source 0 tied low.
module rv_plic_src_filter #(
  parameter int NumSrc     = 64,
  parameter int SyncStages = 2,   // must be >= 2
  parameter int CntW       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  rv_plic_src_filter_if.slave   bus
);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHK    = 1'b1
  } state_e;

  localparam logic [CntW-1:0] CntMax = '1;

  logic [NumSrc-1:0] sync_q [SyncStages];
  logic [NumSrc-1:0] s;

  state_e            state_q [NumSrc];
  state_e            state_d [NumSrc];
  logic [CntW-1:0]   cnt_q   [NumSrc];
  logic [CntW-1:0]   cnt_d   [NumSrc];
  logic [NumSrc-1:0] lvl_q, lvl_d;
  logic [NumSrc-1:0] glitch_q, glitch_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values and the chain shifts by exactly one stage per clock.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < SyncStages; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= bus.raw_i;
      for (int k = 1; k < SyncStages; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[SyncStages-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumSrc; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      lvl_q    <= '0;
      glitch_q <= '0;
    end else begin
      for (int i = 0; i < NumSrc; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      lvl_q    <= lvl_d;
      glitch_q <= glitch_d;
    end
  end

  // Bypass and a finished/abandoned check both land in STABLE with cnt cleared,
  // so those are the defaults and only the counting branch overrides them.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    lvl_d    = lvl_q;
    glitch_d = '0;
    for (int i = 0; i < NumSrc; i++) begin
      state_d[i] = ST_STABLE;
      cnt_d[i]   = '0;

      if (!bus.filt_en_i[i]) begin
        lvl_d[i] = s[i];
      end else begin
        case (state_q[i])
          ST_STABLE: begin
            if (s[i] != lvl_q[i]) begin
              state_d[i] = ST_CHK;
            end
          end
          ST_CHK: begin
            if (s[i] == lvl_q[i]) begin
              glitch_d[i] = 1'b1;
            end else if (cnt_q[i] >= bus.deb_cycles_i) begin
              // >= keeps a lowered threshold from stranding the check.
              lvl_d[i] = ~lvl_q[i];
            end else begin
              state_d[i] = ST_CHK;
              cnt_d[i]   = (cnt_q[i] == CntMax) ? CntMax : cnt_q[i] + 1'b1;
            end
          end
        endcase
      end
    end

    // PLIC source ID 0 means "no interrupt"; pin it low.
    lvl_d[0]    = 1'b0;
    glitch_d[0] = 1'b0;
  end

  assign bus.intr_src_o = lvl_q;
  assign bus.glitch_o   = glitch_q;

endmodule

// File: tb/tb_rv_plic_src_filter.sv
// Self-checking bench for rv_plic_src_filter: directed scenarios plus randomized traffic
// compared against a run-length reference model of the conditioning rules.
module tb_rv_plic_src_filter;

  localparam int NumSrc     = 64;
  localparam int SyncStages = 2;
  localparam int CntW       = 4;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;

  always #5 clk_i = ~clk_i;

  rv_plic_src_filter_if #(.NumSrc(NumSrc), .CntW(CntW)) bus ();

  rv_plic_src_filter #(
    .NumSrc     (NumSrc),
    .SyncStages (SyncStages),
    .CntW       (CntW)
  ) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: raw delayed SyncStages edges gives s; a filtered source flips
  // once s has disagreed with the output for D+2 consecutive samples, and a run
  // that ends early is reported as one glitch.
  logic [NumSrc-1:0] m_pipe [SyncStages];
  logic [NumSrc-1:0] m_out;
  logic [NumSrc-1:0] m_glitch;
  int                m_run  [NumSrc];

  localparam logic [NumSrc-1:0] AllButZero = {{(NumSrc-1){1'b1}}, 1'b0};

  task automatic model_edge();
    logic [NumSrc-1:0] s;
    s        = m_pipe[SyncStages-1];
    m_glitch = '0;
    if (!rst_ni) begin
      for (int k = 0; k < SyncStages; k++) m_pipe[k] = '0;
      for (int i = 0; i < NumSrc; i++) m_run[i] = 0;
      m_out = '0;
      return;
    end
    for (int i = 1; i < NumSrc; i++) begin
      if (!bus.filt_en_i[i]) begin
        m_out[i] = s[i];
        m_run[i] = 0;
      end else if (s[i] != m_out[i]) begin
        m_run[i]++;
        if (m_run[i] >= int'(bus.deb_cycles_i) + 2) begin
          m_out[i] = s[i];
          m_run[i] = 0;
        end
      end else if (m_run[i] > 0) begin
        m_glitch[i] = 1'b1;
        m_run[i]    = 0;
      end
    end
    for (int k = SyncStages - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
    m_pipe[0] = bus.raw_i;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    bus.raw_i = '0;
    repeat (24) tick();
  endtask

  task automatic test_reset();
    bus.raw_i        = {$urandom, $urandom};
    bus.filt_en_i    = {$urandom, $urandom};
    bus.deb_cycles_i = 4'd3;
    rst_ni           = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (bus.intr_src_o !== '0) begin
      n_err++;
      $display("FAIL reset_intr: got %h want 0", bus.intr_src_o);
    end
    n_cmp++;
    if (bus.glitch_o !== '0) begin
      n_err++;
      $display("FAIL reset_glitch: got %h want 0", bus.glitch_o);
    end
    rst_ni = 1'b1;
    settle();
    n_cmp++;
    if (bus.intr_src_o !== m_out) begin
      n_err++;
      $display("FAIL reset_settle: got %h want %h", bus.intr_src_o, m_out);
    end
  endtask

  task automatic test_bypass();
    logic exp;
    bus.filt_en_i = '0;
    settle();
    bus.raw_i[5] = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick();
      exp = (e >= SyncStages + 1);
      n_cmp++;
      if (bus.intr_src_o[5] !== exp) begin
        n_err++;
        $display("FAIL bypass_out5 edge %0d: got %b want %b", e, bus.intr_src_o[5], exp);
      end
      n_cmp++;
      if (bus.glitch_o !== '0) begin
        n_err++;
        $display("FAIL bypass_glitch edge %0d: got %h want 0", e, bus.glitch_o);
      end
    end
  endtask

  task automatic test_filter_pass();
    logic exp;
    bus.filt_en_i    = '1;
    bus.deb_cycles_i = 4'd3;
    settle();
    bus.raw_i[7] = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 6) bus.raw_i[7] = 1'b0;
      tick();
      exp = (e >= 7 && e < 12);
      n_cmp++;
      if (bus.intr_src_o[7] !== exp) begin
        n_err++;
        $display("FAIL filter_pass_out7 edge %0d: got %b want %b", e, bus.intr_src_o[7], exp);
      end
      n_cmp++;
      if (bus.glitch_o[7] !== 1'b0) begin
        n_err++;
        $display("FAIL filter_pass_glitch7 edge %0d: got %b want 0", e, bus.glitch_o[7]);
      end
    end
  endtask

  task automatic test_filter_reject();
    int pulses;
    pulses = 0;
    settle();
    bus.raw_i[7] = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      if (e == 5) bus.raw_i[7] = 1'b0;
      tick();
      if (bus.glitch_o[7] === 1'b1) pulses++;
      n_cmp++;
      if (bus.intr_src_o[7] !== 1'b0) begin
        n_err++;
        $display("FAIL reject_out7 edge %0d: got %b want 0", e, bus.intr_src_o[7]);
      end
      n_cmp++;
      if (bus.glitch_o[7] !== (e == 7)) begin
        n_err++;
        $display("FAIL reject_glitch7 edge %0d: got %b want %b", e, bus.glitch_o[7], (e == 7));
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_err++;
      $display("FAIL reject_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_deb_lower_and_mode();
    logic exp;
    bus.filt_en_i    = '1;
    bus.deb_cycles_i = 4'd7;
    settle();
    bus.raw_i[9] = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      if (e == 8) bus.deb_cycles_i = 4'd1;
      tick();
      exp = (e >= 8);
      n_cmp++;
      if (bus.intr_src_o[9] !== exp) begin
        n_err++;
        $display("FAIL deb_lower_out9 edge %0d: got %b want %b", e, bus.intr_src_o[9], exp);
      end
    end
    bus.deb_cycles_i = 4'd7;
    bus.raw_i[9]     = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      if (e == 6) bus.filt_en_i[9] = 1'b0;
      tick();
      exp = (e < 6);
      n_cmp++;
      if (bus.intr_src_o[9] !== exp) begin
        n_err++;
        $display("FAIL mode_drop_out9 edge %0d: got %b want %b", e, bus.intr_src_o[9], exp);
      end
      n_cmp++;
      if (bus.glitch_o[9] !== 1'b0) begin
        n_err++;
        $display("FAIL mode_drop_glitch9 edge %0d: got %b want 0", e, bus.glitch_o[9]);
      end
    end
    bus.filt_en_i = '1;
  endtask

  task automatic test_reset_mid_check();
    logic [NumSrc-1:0] exp;
    bus.filt_en_i    = '1;
    bus.deb_cycles_i = 4'd3;
    settle();
    bus.raw_i = '1;
    repeat (4) tick();
    rst_ni = 1'b0;
    tick();
    n_cmp++;
    if (bus.intr_src_o !== '0 || bus.glitch_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid_outputs: got %h/%h want 0/0", bus.intr_src_o, bus.glitch_o);
    end
    rst_ni = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e >= SyncStages + 2 + 3) ? AllButZero : '0;
      n_cmp++;
      if (bus.intr_src_o !== exp) begin
        n_err++;
        $display("FAIL reset_mid_requal edge %0d: got %h want %h", e, bus.intr_src_o, exp);
      end
    end
  endtask

  task automatic test_random();
    bus.filt_en_i    = {$urandom, $urandom};
    bus.deb_cycles_i = CntW'($urandom_range(0, 4));
    for (int c = 0; c < 500; c++) begin
      if (c % 40 == 39) begin
        bus.deb_cycles_i = CntW'($urandom_range(0, 5));
        bus.filt_en_i    = bus.filt_en_i ^ ({$urandom, $urandom} & {$urandom, $urandom});
      end
      bus.raw_i    = bus.raw_i ^ ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      bus.raw_i[0] = ~bus.raw_i[0];
      tick();
      n_cmp++;
      if (bus.intr_src_o !== m_out) begin
        n_err++;
        $display("FAIL random_intr cyc %0d: got %h want %h", c, bus.intr_src_o, m_out);
      end
      n_cmp++;
      if (bus.glitch_o !== m_glitch) begin
        n_err++;
        $display("FAIL random_glitch cyc %0d: got %h want %h", c, bus.glitch_o, m_glitch);
      end
      n_cmp++;
      if (bus.intr_src_o[0] !== 1'b0 || bus.glitch_o[0] !== 1'b0) begin
        n_err++;
        $display("FAIL random_src0 cyc %0d: got %b/%b want 0/0", c, bus.intr_src_o[0], bus.glitch_o[0]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.raw_i        = '0;
    bus.filt_en_i    = '0;
    bus.deb_cycles_i = '0;
    m_out            = '0;
    m_glitch         = '0;
    for (int k = 0; k < SyncStages; k++) m_pipe[k] = '0;
    for (int i = 0; i < NumSrc; i++) m_run[i] = 0;

    test_reset();
    test_bypass();
    test_filter_pass();
    test_filter_reject();
    test_deb_lower_and_mode();
    test_reset_mid_check();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
